// File: rtl/iommu_fq_writer.sv
// Fault-queue writer: packs fault reports into 32-byte records and writes them into the
// memory-resident circular fault queue. Define IOMMU_FQ_IOTVAL2_EN to carry iotval2 in beat 3.
module iommu_fq_writer #(
    parameter int LOG2_MAX_ENTRIES = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [43:0]                 fqb_ppn_i,
    input  logic [4:0]                  fqb_log2szm1_i,
    input  logic [LOG2_MAX_ENTRIES-1:0] fqh_i,
    input  logic                        fqen_i,
    input  logic                        fqmf_clr_i,
    input  logic                        fqof_clr_i,
    input  logic                        fip_clr_i,
    input  logic                        ev_valid_i,
    output logic                        ev_ready_o,
    input  logic [11:0]                 ev_cause_i,
    input  logic [5:0]                  ev_ttyp_i,
    input  logic [23:0]                 ev_did_i,
    input  logic [19:0]                 ev_pid_i,
    input  logic                        ev_pv_i,
    input  logic                        ev_priv_i,
    input  logic [63:0]                 ev_iotval_i,
    input  logic [63:0]                 ev_iotval2_i,
    output logic                        mem_req_o,
    output logic [63:0]                 mem_addr_o,
    output logic [63:0]                 mem_wdata_o,
    output logic                        mem_last_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_resp_i,
    input  logic                        mem_err_i,
    output logic [LOG2_MAX_ENTRIES-1:0] fqt_o,
    output logic                        fqon_o,
    output logic                        fqmf_o,
    output logic                        fqof_o,
    output logic                        fip_o,
    output logic [1:0]                  dbg_state_o
);

    // Event handshake: an event transfers on a rising edge where ev_valid_i && ev_ready_o;
    // memory beats transfer on a rising edge where mem_req_o && mem_gnt_i.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [5:0]                  MAX_SZ = 6'(LOG2_MAX_ENTRIES);
    localparam logic [LOG2_MAX_ENTRIES-1:0] ONE    = 1;

    state_e                      state_q, state_d;
    logic [LOG2_MAX_ENTRIES-1:0] tail_q, tail_d, mask, tail_inc;
    logic [1:0]                  beat_q, beat_d;
    logic [63:0]                 beat0_q, iotval_q, addr_q, rec_addr, beat3;
    logic [5:0]                  qsz;
    logic                        fqmf_q, fqof_q, fip_q, ready_q, ready_d;
    logic                        ev_fire, full, latch_ev, set_of, set_mf, set_fip, clr_flags;

`ifdef IOMMU_FQ_IOTVAL2_EN
    logic [63:0] iotval2_q;
    assign beat3 = iotval2_q;
`else
    logic unused_iotval2;
    assign unused_iotval2 = ^ev_iotval2_i;
    assign beat3          = '0;
`endif

    // Queue size is 2^(log2szm1+1) records, never larger than the pointer width allows.
    always_comb begin
        qsz = {1'b0, fqb_log2szm1_i} + 6'd1;
        if (qsz > MAX_SZ) qsz = MAX_SZ;
        mask = '0;
        for (int i = 0; i < LOG2_MAX_ENTRIES; i++) begin
            mask[i] = (i < int'(qsz));
        end
    end

    assign tail_inc = (tail_q + ONE) & mask;
    assign full     = (tail_inc == fqh_i);
    assign rec_addr = {8'd0, fqb_ppn_i, 12'd0}
                    + ({{(64-LOG2_MAX_ENTRIES){1'b0}}, tail_q} << 5);
    assign ev_fire  = ev_valid_i & ready_q;

    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        beat_d     = beat_q;
        latch_ev   = 1'b0;
        set_of     = 1'b0;
        set_mf     = 1'b0;
        set_fip    = 1'b0;
        clr_flags  = 1'b0;
        mem_req_o  = 1'b0;
        mem_last_o = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (fqen_i) begin
                    state_d   = ST_IDLE;
                    tail_d    = '0;
                    clr_flags = 1'b1;
                end
            end
            ST_IDLE: begin
                if (!fqen_i) begin
                    state_d = ST_OFF;
                end else if (ev_fire && !fqmf_q && !fqof_q) begin
                    if (full) begin
                        set_of = 1'b1;
                    end else begin
                        latch_ev = 1'b1;
                        beat_d   = 2'd0;
                        state_d  = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                mem_req_o  = 1'b1;
                mem_last_o = (beat_q == 2'd3);
                if (mem_gnt_i) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_resp_i) begin
                    if (mem_err_i) begin
                        set_mf = 1'b1;
                    end else begin
                        tail_d  = tail_inc;
                        set_fip = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Ready is registered so it reads 0 while reset is held.
    assign ready_d = (state_d == ST_OFF) || (state_d == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_OFF;
            tail_q   <= '0;
            beat_q   <= '0;
            ready_q  <= 1'b0;
            beat0_q  <= '0;
            iotval_q <= '0;
            addr_q   <= '0;
            fqmf_q   <= 1'b0;
            fqof_q   <= 1'b0;
            fip_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            beat_q  <= beat_d;
            ready_q <= ready_d;
            if (latch_ev) begin
                beat0_q  <= {ev_did_i, ev_ttyp_i, ev_priv_i, ev_pv_i, ev_pid_i, ev_cause_i};
                iotval_q <= ev_iotval_i;
                addr_q   <= rec_addr;
            end
            // Set beats a same-cycle clear pulse.
            if (set_mf)                        fqmf_q <= 1'b1;
            else if (clr_flags || fqmf_clr_i)  fqmf_q <= 1'b0;
            if (set_of)                        fqof_q <= 1'b1;
            else if (clr_flags || fqof_clr_i)  fqof_q <= 1'b0;
            if (set_fip)                       fip_q  <= 1'b1;
            else if (fip_clr_i)                fip_q  <= 1'b0;
        end
    end

`ifdef IOMMU_FQ_IOTVAL2_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       iotval2_q <= '0;
        else if (latch_ev) iotval2_q <= ev_iotval2_i;
    end
`endif

    always_comb begin
        case (beat_q)
            2'd0:    mem_wdata_o = beat0_q;
            2'd1:    mem_wdata_o = '0;
            2'd2:    mem_wdata_o = iotval_q;
            default: mem_wdata_o = beat3;
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign ev_ready_o  = ready_q;
    assign fqt_o       = tail_q;
    assign fqon_o      = (state_q != ST_OFF);
    assign fqmf_o      = fqmf_q;
    assign fqof_o      = fqof_q;
    assign fip_o       = fip_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iommu_fq_writer.sv
// Directed bench for iommu_fq_writer: drives fault reports, acts as the memory target and
// compares every beat, pointer and flag against hand-computed expectations.
module tb_iommu_fq_writer;

    localparam int L = 12;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [43:0]   fqb_ppn_i = '0;
    logic [4:0]    fqb_log2szm1_i = '0;
    logic [L-1:0]  fqh_i = '0;
    logic          fqen_i = 1'b0, fqmf_clr_i = 1'b0, fqof_clr_i = 1'b0, fip_clr_i = 1'b0;
    logic          ev_valid_i = 1'b0, ev_ready_o;
    logic [11:0]   ev_cause_i = '0;
    logic [5:0]    ev_ttyp_i = '0;
    logic [23:0]   ev_did_i = '0;
    logic [19:0]   ev_pid_i = '0;
    logic          ev_pv_i = 1'b0, ev_priv_i = 1'b0;
    logic [63:0]   ev_iotval_i = '0, ev_iotval2_i = '0;
    logic          mem_req_o, mem_last_o;
    logic [63:0]   mem_addr_o, mem_wdata_o;
    logic          mem_gnt_i = 1'b0, mem_resp_i = 1'b0, mem_err_i = 1'b0;
    logic [L-1:0]  fqt_o;
    logic          fqon_o, fqmf_o, fqof_o, fip_o;
    logic [1:0]    dbg_state_o;

    logic [63:0] exp_q[$];
    int total = 0;
    int bad = 0;

    iommu_fq_writer #(.LOG2_MAX_ENTRIES(L)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .fqb_ppn_i(fqb_ppn_i), .fqb_log2szm1_i(fqb_log2szm1_i), .fqh_i(fqh_i),
        .fqen_i(fqen_i), .fqmf_clr_i(fqmf_clr_i), .fqof_clr_i(fqof_clr_i), .fip_clr_i(fip_clr_i),
        .ev_valid_i(ev_valid_i), .ev_ready_o(ev_ready_o), .ev_cause_i(ev_cause_i),
        .ev_ttyp_i(ev_ttyp_i), .ev_did_i(ev_did_i), .ev_pid_i(ev_pid_i), .ev_pv_i(ev_pv_i),
        .ev_priv_i(ev_priv_i), .ev_iotval_i(ev_iotval_i), .ev_iotval2_i(ev_iotval2_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_last_o(mem_last_o), .mem_gnt_i(mem_gnt_i), .mem_resp_i(mem_resp_i),
        .mem_err_i(mem_err_i), .fqt_o(fqt_o), .fqon_o(fqon_o), .fqmf_o(fqmf_o),
        .fqof_o(fqof_o), .fip_o(fip_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat3(input logic [63:0] v2);
`ifdef IOMMU_FQ_IOTVAL2_EN
        return v2;
`else
        return 64'd0;
`endif
    endfunction

    task automatic push_record(input logic [11:0] c, input logic [5:0] t, input logic [23:0] d,
                               input logic [19:0] p, input logic pv, input logic pr,
                               input logic [63:0] v1, input logic [63:0] v2);
        exp_q.push_back({d, t, pr, pv, p, c});
        exp_q.push_back(64'd0);
        exp_q.push_back(v1);
        exp_q.push_back(exp_beat3(v2));
    endtask

    // driver: present one event and hold it until accepted (bounded)
    task automatic send_event(input logic [11:0] c, input logic [5:0] t, input logic [23:0] d,
                              input logic [19:0] p, input logic pv, input logic pr,
                              input logic [63:0] v1, input logic [63:0] v2);
        bit done = 1'b0;
        ev_cause_i = c; ev_ttyp_i = t; ev_did_i = d; ev_pid_i = p;
        ev_pv_i = pv; ev_priv_i = pr; ev_iotval_i = v1; ev_iotval2_i = v2;
        ev_valid_i = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (ev_ready_o) done = 1'b1;
            @(negedge clk);
        end
        ev_valid_i = 1'b0;
        check_val("ev_accept", 64'(done), 64'd1);
    endtask

    // memory target: grants every beat except a stall on one beat, then responds
    task automatic serve_record(input logic [63:0] addr, input int stall_beat, input int stall_n,
                                input logic err);
        logic [63:0] exp;
        mem_gnt_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            exp = '0;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else check_val("exp_q_empty", 64'd1, 64'd0);
            check_val("beat_req", 64'(mem_req_o), 64'd1);
            check_val("beat_addr", mem_addr_o, addr);
            check_val("beat_data", mem_wdata_o, exp);
            check_val("beat_last", 64'(mem_last_o), 64'(b == 3));
            if (b == stall_beat) begin
                mem_gnt_i = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    check_val("stall_req", 64'(mem_req_o), 64'd1);
                    check_val("stall_addr", mem_addr_o, addr);
                    check_val("stall_data", mem_wdata_o, exp);
                end
                mem_gnt_i = 1'b1;
            end
            @(negedge clk);
        end
        mem_gnt_i = 1'b0;
        check_val("resp_no_req", 64'(mem_req_o), 64'd0);
        check_val("resp_not_ready", 64'(ev_ready_o), 64'd0);
        mem_resp_i = 1'b1; mem_err_i = err;
        @(negedge clk);
        mem_resp_i = 1'b0; mem_err_i = 1'b0;
        check_val("post_resp_ready", 64'(ev_ready_o), 64'd1);
    endtask

    task automatic no_traffic(input int n);
        mem_gnt_i = 1'b1;
        repeat (n) begin
            check_val("no_req", 64'(mem_req_o), 64'd0);
            @(negedge clk);
        end
        mem_gnt_i = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: fqmf_clr_i = 1'b1;
            1: fqof_clr_i = 1'b1;
            default: fip_clr_i = 1'b1;
        endcase
        @(negedge clk);
        fqmf_clr_i = 1'b0; fqof_clr_i = 1'b0; fip_clr_i = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        check_val("rst_ready", 64'(ev_ready_o), 64'd0);
        check_val("rst_req", 64'(mem_req_o), 64'd0);
        check_val("rst_fqon", 64'(fqon_o), 64'd0);
        check_val("rst_fqt", 64'(fqt_o), 64'd0);
        check_val("rst_flags", {61'd0, fqmf_o, fqof_o, fip_o}, 64'd0);
        check_val("rst_state", 64'(dbg_state_o), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk); @(negedge clk);
        check_val("off_ready", 64'(ev_ready_o), 64'd1);
        check_val("off_fqon", 64'(fqon_o), 64'd0);

        // single record
        fqb_ppn_i = 44'h80000; fqb_log2szm1_i = 5'd3; fqh_i = '0; fqen_i = 1'b1;
        @(negedge clk);
        check_val("en_fqon", 64'(fqon_o), 64'd1);
        check_val("en_fqt", 64'(fqt_o), 64'd0);
        exp_q.push_back(64'h0001_2309_0004_5102);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'hDEAD);
        exp_q.push_back(exp_beat3(64'hBEEF_0001));
        send_event(12'd258, 6'h02, 24'h000123, 20'h45, 1'b1, 1'b0, 64'hDEAD, 64'hBEEF_0001);
        serve_record(BASE, -1, 0, 1'b0);
        check_val("t1_fqt", 64'(fqt_o), 64'd1);
        check_val("t1_fip", 64'(fip_o), 64'd1);
        mem_resp_i = 1'b1; @(negedge clk); mem_resp_i = 1'b0;
        check_val("stray_resp_fqt", 64'(fqt_o), 64'd1);
        pulse(2);
        check_val("fip_clr", 64'(fip_o), 64'd0);

        // re-enable resets the tail; fill the 16-entry queue
        fqen_i = 1'b0; @(negedge clk); @(negedge clk);
        check_val("dis_fqon", 64'(fqon_o), 64'd0);
        fqen_i = 1'b1; @(negedge clk);
        check_val("reen_fqt", 64'(fqt_o), 64'd0);
        for (int i = 0; i < 15; i++) begin
            push_record(12'(i + 1), 6'(i), 24'(i * 7 + 3), 20'(i * 13), i[0], i[1],
                        64'(i) << 8, 64'h55 + 64'(i));
            send_event(12'(i + 1), 6'(i), 24'(i * 7 + 3), 20'(i * 13), i[0], i[1],
                       64'(i) << 8, 64'h55 + 64'(i));
            serve_record(BASE + 64'(i * 32), -1, 0, 1'b0);
        end
        check_val("fill_fqt", 64'(fqt_o), 64'd15);
        fqof_clr_i = 1'b1;
        send_event(12'h7, 6'h1, 24'h1, 20'h1, 1'b0, 1'b0, 64'h1, 64'h2);
        fqof_clr_i = 1'b0;
        check_val("full_fqof", 64'(fqof_o), 64'd1);
        no_traffic(3);
        check_val("full_fqt", 64'(fqt_o), 64'd15);
        send_event(12'h8, 6'h1, 24'h1, 20'h1, 1'b0, 1'b0, 64'h1, 64'h2);
        no_traffic(3);
        fqh_i = 12'd5;
        pulse(1);
        check_val("fqof_clr", 64'(fqof_o), 64'd0);
        push_record(12'hABC, 6'h3F, 24'hFEDCBA, 20'hFFFFF, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0,
                    64'h0FED_CBA9_8765_4321);
        send_event(12'hABC, 6'h3F, 24'hFEDCBA, 20'hFFFFF, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0,
                   64'h0FED_CBA9_8765_4321);
        serve_record(64'h8000_01E0, -1, 0, 1'b0);
        check_val("wrap_fqt", 64'(fqt_o), 64'd0);

        // memory error
        push_record(12'h11, 6'h4, 24'h42, 20'h9, 1'b0, 1'b1, 64'hA5A5, 64'h5A5A);
        send_event(12'h11, 6'h4, 24'h42, 20'h9, 1'b0, 1'b1, 64'hA5A5, 64'h5A5A);
        serve_record(BASE, -1, 0, 1'b1);
        check_val("err_fqmf", 64'(fqmf_o), 64'd1);
        check_val("err_fqt", 64'(fqt_o), 64'd0);
        send_event(12'h12, 6'h4, 24'h42, 20'h9, 1'b0, 1'b0, 64'h1, 64'h1);
        no_traffic(3);
        check_val("mf_drop_fqt", 64'(fqt_o), 64'd0);
        pulse(0);
        check_val("fqmf_clr", 64'(fqmf_o), 64'd0);

        // grant stall on beat 2
        push_record(12'h3C, 6'h2A, 24'h00BEEF, 20'h12345, 1'b1, 1'b0, 64'hCAFE_F00D, 64'h77);
        send_event(12'h3C, 6'h2A, 24'h00BEEF, 20'h12345, 1'b1, 1'b0, 64'hCAFE_F00D, 64'h77);
        serve_record(BASE, 2, 3, 1'b0);
        check_val("stall_fqt", 64'(fqt_o), 64'd1);

        // disable while writing
        push_record(12'h5, 6'h5, 24'h5, 20'h5, 1'b1, 1'b1, 64'h5, 64'h6);
        send_event(12'h5, 6'h5, 24'h5, 20'h5, 1'b1, 1'b1, 64'h5, 64'h6);
        fqen_i = 1'b0;
        serve_record(BASE + 64'd32, -1, 0, 1'b0);
        check_val("dis_fqt", 64'(fqt_o), 64'd2);
        check_val("dis_idle_fqon", 64'(fqon_o), 64'd1);
        @(negedge clk);
        check_val("dis_off_fqon", 64'(fqon_o), 64'd0);
        send_event(12'h6, 6'h6, 24'h6, 20'h6, 1'b0, 1'b0, 64'h6, 64'h6);
        no_traffic(4);

        // reset mid-write
        fqen_i = 1'b1; @(negedge clk);
        check_val("t6_fqt", 64'(fqt_o), 64'd0);
        send_event(12'h9, 6'h9, 24'h9, 20'h9, 1'b0, 1'b0, 64'h9, 64'h9);
        check_val("t6_req", 64'(mem_req_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_val("mid_rst_req", 64'(mem_req_o), 64'd0);
        check_val("mid_rst_ready", 64'(ev_ready_o), 64'd0);
        check_val("mid_rst_addr", mem_addr_o, 64'd0);
        check_val("mid_rst_data", mem_wdata_o, 64'd0);
        check_val("mid_rst_misc", {58'd0, mem_last_o, fqon_o, fqmf_o, fqof_o, fip_o, 1'b0}, 64'd0);
        check_val("mid_rst_fqt", 64'(fqt_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        no_traffic(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
